branch_target_buffer: RTL

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

---
 rtl/branch_target_buffer.sv | 103 ++++++++++
 1 files changed

// File: rtl/branch_target_buffer.sv
`default_nettype none
// ============================================================================
// Module   : branch_target_buffer
// Brief    : 8-entry fully associative BTB with 2-bit saturating counters,
//            lowest-invalid-first allocation and round-robin replacement.
// Revision : 1.0
// ============================================================================
module branch_target_buffer #(
  parameter logic [1:0] ALLOC_STATE = 2'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  output logic        v1, v2, v3, v4, v5, v6, v7, v8,
  output logic [31:0] A1, A2, A3, A4, A5, A6, A7, A8,
  output logic [31:0] B1, B2, B3, B4, B5, B6, B7, B8,
  output logic [1:0]  s1, s2, s3, s4, s5, s6, s7, s8,
  output logic [3:0]  count
);

  localparam int c_N = 8;

  logic [c_N-1:0] r_v;
  logic [31:0]    r_a [c_N];
  logic [31:0]    r_b [c_N];
  logic [1:0]     r_s [c_N];
  logic [2:0]     r_rr;
  logic [3:0]     r_count;

  logic           w_hit;
  logic [2:0]     w_hit_idx;
  logic           w_free;
  logic [2:0]     w_free_idx;
  logic [2:0]     w_victim;

  // Descending scan so the lowest matching / free index wins.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = 3'd0;
    w_free     = 1'b0;
    w_free_idx = 3'd0;
    for (int i = c_N - 1; i >= 0; i--) begin
      if (r_v[i] && (r_a[i] == upd_pc)) begin
        w_hit     = 1'b1;
        w_hit_idx = 3'(i);
      end
      if (!r_v[i]) begin
        w_free     = 1'b1;
        w_free_idx = 3'(i);
      end
    end
    w_victim = w_free ? w_free_idx : r_rr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v     <= '0;
      r_rr    <= 3'd0;
      r_count <= 4'd0;
      for (int i = 0; i < c_N; i++) begin
        r_a[i] <= 32'd0;
        r_b[i] <= 32'd0;
        r_s[i] <= 2'd0;
      end
    end else if (clr) begin
      r_v     <= '0;
      r_rr    <= 3'd0;
      r_count <= 4'd0;
    end else if (upd_en) begin
      if (w_hit) begin
        if (upd_taken) begin
          if (r_s[w_hit_idx] != 2'd3) r_s[w_hit_idx] <= r_s[w_hit_idx] + 2'd1;
          r_b[w_hit_idx] <= upd_target;
        end else if (r_s[w_hit_idx] != 2'd0) begin
          r_s[w_hit_idx] <= r_s[w_hit_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        r_v[w_victim] <= 1'b1;
        r_a[w_victim] <= upd_pc;
        r_b[w_victim] <= upd_target;
        r_s[w_victim] <= ALLOC_STATE;
        // Only filling a hole grows the table; replacing a live entry steps rr.
        if (w_free) r_count <= r_count + 4'd1;
        else        r_rr    <= r_rr + 3'd1;
      end
    end
  end

  assign {v8, v7, v6, v5, v4, v3, v2, v1} = r_v;
  assign A1 = r_a[0]; assign A2 = r_a[1]; assign A3 = r_a[2]; assign A4 = r_a[3];
  assign A5 = r_a[4]; assign A6 = r_a[5]; assign A7 = r_a[6]; assign A8 = r_a[7];
  assign B1 = r_b[0]; assign B2 = r_b[1]; assign B3 = r_b[2]; assign B4 = r_b[3];
  assign B5 = r_b[4]; assign B6 = r_b[5]; assign B7 = r_b[6]; assign B8 = r_b[7];
  assign s1 = r_s[0]; assign s2 = r_s[1]; assign s3 = r_s[2]; assign s4 = r_s[3];
  assign s5 = r_s[4]; assign s6 = r_s[5]; assign s7 = r_s[6]; assign s8 = r_s[7];
  assign count = r_count;

endmodule
`default_nettype wire
